// File: rtl/esc_halfduplex_uart.sv
// esc_halfduplex_uart: half-duplex one-wire 8N1 UART for ESC passthrough, holds the line through a turnaround guard before releasing OE.
// Build option ESC_UART_RX_MAJORITY_EN: RX decisions use a 2-of-3 majority around each bit center.
module esc_halfduplex_uart #(
  parameter int CLKS_PER_BIT    = 2813,
  parameter int TURNAROUND_BITS = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       busy_o,
  output logic       serial_tx_o,
  output logic       serial_oe_o,
  input  logic       serial_rx_i
);
  localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_STOP = 3'd3, TX_HOLD = 3'd4;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam int HOLD_CYC = TURNAROUND_BITS * CLKS_PER_BIT;
  localparam int TCW = $clog2((TURNAROUND_BITS + 1) * CLKS_PER_BIT);
  localparam int RCW = $clog2(CLKS_PER_BIT);
`ifdef ESC_UART_RX_MAJORITY_EN
  localparam int SAMP_OFF = 1;
`else
  localparam int SAMP_OFF = 0;
`endif
  localparam logic [TCW-1:0] BIT_END  = TCW'(CLKS_PER_BIT - 1);
  localparam logic [TCW-1:0] HOLD_END = TCW'(HOLD_CYC - 1);
  localparam logic [RCW-1:0] RX_END   = RCW'(CLKS_PER_BIT - 1);
  localparam logic [RCW-1:0] RX_MID   = RCW'(CLKS_PER_BIT / 2 + SAMP_OFF);
  logic [2:0]     tx_st, tx_idx, rx_idx;
  logic [1:0]     rx_st;
  logic [TCW-1:0] tx_cnt;
  logic [RCW-1:0] rx_cnt;
  logic [7:0]     tx_sh, rx_sh;
  logic           rx_s1, rx_s2, rx_prev, rx_smp, rx_fall, tx_acc;
  assign tx_ready_o = (tx_st == TX_IDLE || tx_st == TX_HOLD) && rx_st == RX_IDLE;
  assign tx_acc     = tx_valid_i & tx_ready_o;
  assign busy_o     = (tx_st != TX_IDLE) || (rx_st != RX_IDLE);
  assign rx_fall    = rx_prev & ~rx_s2;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= serial_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
`ifdef ESC_UART_RX_MAJORITY_EN
  logic rx_prev2;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) rx_prev2 <= 1'b1;
    else rx_prev2 <= rx_prev;
  // samples at center+1, center, center-1; decision taken at center+1
  assign rx_smp = (rx_s2 & rx_prev) | (rx_s2 & rx_prev2) | (rx_prev & rx_prev2);
`else
  assign rx_smp = rx_s2;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      tx_st       <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_sh       <= '0;
      serial_tx_o <= 1'b1;
      serial_oe_o <= 1'b0;
    end else if (tx_acc) begin
      tx_st       <= TX_START;
      tx_cnt      <= '0;
      tx_sh       <= tx_data_i;
      serial_tx_o <= 1'b0;
      serial_oe_o <= 1'b1;
    end else if (tx_st != TX_IDLE) begin
      tx_cnt <= tx_cnt + TCW'(1);
      case (tx_st)
        TX_START: if (tx_cnt == BIT_END) begin
          tx_st       <= TX_DATA;
          tx_cnt      <= '0;
          tx_idx      <= '0;
          serial_tx_o <= tx_sh[0];
        end
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt      <= '0;
          tx_idx      <= tx_idx + 3'd1;
          tx_sh       <= tx_sh >> 1;
          serial_tx_o <= (tx_idx == 3'd7) ? 1'b1 : tx_sh[1];
          tx_st       <= (tx_idx == 3'd7) ? TX_STOP : TX_DATA;
        end
        TX_STOP: if (tx_cnt == BIT_END) begin
          tx_cnt      <= '0;
          tx_st       <= (HOLD_CYC == 0) ? TX_IDLE : TX_HOLD;
          serial_oe_o <= (HOLD_CYC != 0);
        end
        default: if (tx_cnt == HOLD_END) begin
          tx_st       <= TX_IDLE;
          serial_oe_o <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      rx_st          <= RX_IDLE;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_sh          <= '0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_cnt         <= rx_cnt + RCW'(1);
      case (rx_st)
        // own echo is ignored: only listen while released and TX is not starting
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall && !serial_oe_o && tx_st == TX_IDLE && !tx_acc) rx_st <= RX_START;
        end
        RX_START: if (rx_cnt == RX_MID) begin
          rx_cnt <= '0;
          rx_idx <= '0;
          rx_st  <= rx_smp ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == RX_END) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_smp, rx_sh[7:1]};
          rx_idx <= rx_idx + 3'd1;
          rx_st  <= (rx_idx == 3'd7) ? RX_STOP : RX_DATA;
        end
        default: if (rx_cnt == RX_END) begin
          rx_st          <= RX_IDLE;
          rx_valid_o     <= rx_smp;
          rx_frame_err_o <= !rx_smp;
          rx_data_o      <= rx_smp ? rx_sh : rx_data_o;
        end
      endcase
    end
endmodule

// File: tb/tb_esc_halfduplex_uart.sv
// tb_esc_halfduplex_uart: scoreboard bench for esc_halfduplex_uart at CLKS_PER_BIT=16, TURNAROUND_BITS=2.
module tb_esc_halfduplex_uart;
  localparam int C = 16;
  logic       clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, rx_drv = 1'b1, loopback = 1'b0, tx_mon_on = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, rx_err, busy, txl, oe, rx_line;
  logic [7:0] rx_data;
  int         n_tests = 0, n_fail = 0, n_valid = 0, n_err = 0, v0, e0, bad;
  logic [7:0] tx_q[$], rx_q[$];
  always #5 clk = ~clk;
  assign rx_line = loopback ? txl : rx_drv;
  esc_halfduplex_uart #(.CLKS_PER_BIT(C), .TURNAROUND_BITS(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_frame_err_o(rx_err),
    .busy_o(busy), .serial_tx_o(txl), .serial_oe_o(oe), .serial_rx_i(rx_line)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // decodes each transmitted frame from its first start-bit cycle
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (rst_n && tx_mon_on && oe && !txl) begin
      repeat (C / 2) @(negedge clk);
      check("tx_start_bit", {31'd0, txl}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = txl;
        check("tx_oe_data", {31'd0, oe}, 32'd1);
      end
      repeat (C) @(negedge clk);
      check("tx_stop_bit", {31'd0, txl}, 32'd1);
      if (tx_q.size() == 0) check("tx_q_empty", 32'd1, 32'd0);
      else check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (rx_err) n_err++;
    if (rx_valid) begin
      n_valid++;
      if (rx_q.size() == 0) check("rx_q_empty", 32'd1, 32'd0);
      else check("rx_byte", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("tx_accept_wait", {31'd0, tx_ready}, 32'd1);
    if (tx_mon_on) tx_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask
  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (C) @(negedge clk);
    end
    rx_drv = stop;
    repeat (C) @(negedge clk);
    rx_drv = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, txl}, 32'd1);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_err", {31'd0, rx_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // single byte with exact timing
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tx_q.push_back(8'hA5);
    check("rdy_idle", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("oe_rise", {31'd0, oe}, 32'd1);
    check("start_low", {31'd0, txl}, 32'd0);
    repeat (159) @(negedge clk);
    check("oe_in_stop", {31'd0, oe}, 32'd1);
    check("stop_high", {31'd0, txl}, 32'd1);
    repeat (32) @(negedge clk);
    check("oe_hold_end", {31'd0, oe}, 32'd1);
    check("rdy_in_hold", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("oe_drop", {31'd0, oe}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("rdy_after", {31'd0, tx_ready}, 32'd1);
    // back-to-back through HOLD
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tx_q.push_back(8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    bad = 0;
    repeat (164) begin
      @(negedge clk);
      if (!oe) bad++;
    end
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    tx_q.push_back(8'h0F);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_start_low", {31'd0, txl}, 32'd0);
    check("b2b_oe", {31'd0, oe}, 32'd1);
    repeat (190) begin
      @(negedge clk);
      if (!oe) bad++;
    end
    @(negedge clk);
    check("b2b_oe_cont", bad, 32'd0);
    check("b2b_hold_end", {31'd0, oe}, 32'd1);
    @(negedge clk);
    check("b2b_oe_drop", {31'd0, oe}, 32'd0);
    // good RX frame
    v0 = n_valid;
    e0 = n_err;
    rx_q.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_valid_cnt", n_valid - v0, 32'd1);
    check("rx_no_err", n_err - e0, 32'd0);
    check("rx_data_3c", {24'd0, rx_data}, 32'h3C);
    // stop bit low
    v0 = n_valid;
    drive_rx(8'hC3, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_cnt", n_err - e0, 32'd1);
    check("ferr_no_valid", n_valid - v0, 32'd0);
    check("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
    check("ferr_idle", {31'd0, busy}, 32'd0);
    // short low glitch
    e0 = n_err;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_no_pulse", (n_valid - v0) + (n_err - e0), 32'd0);
    // own echo while driving
    loopback = 1'b1;
    send_byte(8'h00);
    send_byte(8'h5A);
    wait_idle();
    loopback = 1'b0;
    repeat (40) @(negedge clk);
    check("echo_no_pulse", (n_valid - v0) + (n_err - e0), 32'd0);
    // TX offered while RX is mid-frame
    v0 = n_valid;
    rx_q.push_back(8'h81);
    fork
      drive_rx(8'h81, 1'b1);
      begin
        int t = 0;
        repeat (40) @(negedge clk);
        tx_data = 8'h77;
        tx_valid = 1'b1;
        tx_q.push_back(8'h77);
        @(negedge clk);
        check("rdy_mid_rx", {31'd0, tx_ready}, 32'd0);
        check("busy_mid_rx", {31'd0, busy}, 32'd1);
        while (!tx_ready && t < 400) begin
          @(negedge clk);
          t++;
        end
        check("rdy_at_rx_end", {31'd0, rx_valid}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_idle();
    check("rx_81_cnt", n_valid - v0, 32'd1);
    // async reset mid-DATA
    tx_mon_on = 1'b0;
    send_byte(8'h00);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe", {31'd0, oe}, 32'd0);
    check("arst_tx", {31'd0, txl}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_mon_on = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h96);
    wait_idle();
    repeat (20) @(negedge clk);
    check("tx_q_drained", tx_q.size(), 32'd0);
    check("rx_q_drained", rx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
